// File: rtl/zoled_pixel_plotter.sv
// rtl/zoled_pixel_plotter.sv - read-modify-write pixel controller for the OLED framebuffer RAM
// Optional per-page dirty tracking is built when ZOLED_DIRTY_PAGE_EN is defined.
module zoled_pixel_plotter #(
  parameter int COLS   = 128,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iReqValid,
  output logic       oReqReady,
  input  logic [6:0] iX,
  input  logic [5:0] iY,
  input  logic [1:0] iOp,
  output logic [9:0] oRamAddr,
  output logic       oRamRdEn,
  input  logic [7:0] iRamRdData,
  output logic       oRamWrEn,
  output logic [7:0] oRamWrData,
  output logic       oDone,
  output logic       oErr,
  output logic       oBusy,
  output logic [7:0] oDirtyPages,
  input  logic [7:0] iDirtyClr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_t;

  localparam logic [7:0] COLS_W    = 8'(COLS);
  localparam logic       WAIT_LAST = 1'(RD_LAT - 1);

  state_t     state;
  logic [7:0] mask_q;
  logic [1:0] op_q;
  logic       wait_cnt;
  logic       in_range;

  assign oReqReady = (state == S_IDLE);
  assign in_range  = ({1'b0, iX} < COLS_W);

  function automatic logic [7:0] apply_op(input logic [7:0] rd, input logic [7:0] m,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return rd & ~m;
      2'b01:   return rd | m;
      2'b10:   return rd ^ m;
      default: return rd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      oRamAddr   <= 10'd0;
      oRamRdEn   <= 1'b0;
      oRamWrEn   <= 1'b0;
      oRamWrData <= 8'h00;
      oDone      <= 1'b0;
      oErr       <= 1'b0;
      oBusy      <= 1'b0;
      mask_q     <= 8'h00;
      op_q       <= 2'b00;
      wait_cnt   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iReqValid) begin
            oBusy <= 1'b1;
            if (in_range) begin
              state    <= S_READ;
              oRamAddr <= {iY[5:3], iX};
              mask_q   <= 8'd1 << iY[2:0];
              op_q     <= iOp;
              oRamRdEn <= 1'b1;
            end else begin
              state <= S_ERR;
              oDone <= 1'b1;
              oErr  <= 1'b1;
            end
          end
        end
        S_READ: begin
          oRamRdEn <= 1'b0;
          wait_cnt <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Write data is formed at the capture edge so the RAM sees a registered value.
          if (wait_cnt == WAIT_LAST) begin
            oRamWrData <= apply_op(iRamRdData, mask_q, op_q);
            oRamWrEn   <= 1'b1;
            oDone      <= 1'b1;
            state      <= S_WRITE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          oRamWrEn <= 1'b0;
          oDone    <= 1'b0;
          oBusy    <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERR: begin
          oDone <= 1'b0;
          oErr  <= 1'b0;
          oBusy <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          oRamRdEn <= 1'b0;
          oRamWrEn <= 1'b0;
          oDone    <= 1'b0;
          oErr     <= 1'b0;
          oBusy    <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ZOLED_DIRTY_PAGE_EN
  logic [7:0] page_bit;

  assign page_bit = (state == S_WRITE) ? (8'd1 << oRamAddr[9:7]) : 8'h00;

  // A set in the same cycle as a clear wins so the refresh engine resends that page.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oDirtyPages <= 8'h00;
    end else begin
      oDirtyPages <= (oDirtyPages & ~iDirtyClr) | page_bit;
    end
  end
`else
  logic unused_dirty_clr;

  assign oDirtyPages      = 8'h00;
  assign unused_dirty_clr = ^iDirtyClr;
`endif

endmodule

// File: tb/tb_zoled_pixel_plotter.sv
// tb/tb_zoled_pixel_plotter.sv - self-checking bench for zoled_pixel_plotter
// Three instances: default, COLS=96, RD_LAT=2; each drives its own framebuffer model.
module tb_zoled_pixel_plotter;

  localparam int N = 3;
`ifdef ZOLED_DIRTY_PAGE_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_valid   [N];
  logic       req_ready   [N];
  logic [6:0] xx          [N];
  logic [5:0] yy          [N];
  logic [1:0] op_in       [N];
  logic [9:0] ram_addr    [N];
  logic       ram_rd_en   [N];
  logic [7:0] ram_rd_data [N];
  logic       ram_wr_en   [N];
  logic [7:0] ram_wr_data [N];
  logic       done        [N];
  logic       err         [N];
  logic       busy        [N];
  logic [7:0] dirty       [N];
  logic [7:0] dirty_clr   [N];

  logic [7:0] mem     [N][1024];
  logic [7:0] ref_mem [N][1024];
  logic [7:0] dirty_exp [N];
  logic [7:0] p1 [N];
  logic [7:0] p2 [N];
  logic [N-1:0] pre_en;
  logic [9:0]   pre_a;
  logic [7:0]   pre_v [N];

  int checks = 0;
  int errors = 0;

  zoled_pixel_plotter u_dut0 (
    .clk(clk), .rst_n(rst_n), .iReqValid(req_valid[0]), .oReqReady(req_ready[0]),
    .iX(xx[0]), .iY(yy[0]), .iOp(op_in[0]), .oRamAddr(ram_addr[0]), .oRamRdEn(ram_rd_en[0]),
    .iRamRdData(ram_rd_data[0]), .oRamWrEn(ram_wr_en[0]), .oRamWrData(ram_wr_data[0]),
    .oDone(done[0]), .oErr(err[0]), .oBusy(busy[0]), .oDirtyPages(dirty[0]),
    .iDirtyClr(dirty_clr[0])
  );

  zoled_pixel_plotter #(.COLS(96), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .iReqValid(req_valid[1]), .oReqReady(req_ready[1]),
    .iX(xx[1]), .iY(yy[1]), .iOp(op_in[1]), .oRamAddr(ram_addr[1]), .oRamRdEn(ram_rd_en[1]),
    .iRamRdData(ram_rd_data[1]), .oRamWrEn(ram_wr_en[1]), .oRamWrData(ram_wr_data[1]),
    .oDone(done[1]), .oErr(err[1]), .oBusy(busy[1]), .oDirtyPages(dirty[1]),
    .iDirtyClr(dirty_clr[1])
  );

  zoled_pixel_plotter #(.COLS(128), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .iReqValid(req_valid[2]), .oReqReady(req_ready[2]),
    .iX(xx[2]), .iY(yy[2]), .iOp(op_in[2]), .oRamAddr(ram_addr[2]), .oRamRdEn(ram_rd_en[2]),
    .iRamRdData(ram_rd_data[2]), .oRamWrEn(ram_wr_en[2]), .oRamWrData(ram_wr_data[2]),
    .oDone(done[2]), .oErr(err[2]), .oBusy(busy[2]), .oDirtyPages(dirty[2]),
    .iDirtyClr(dirty_clr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: data appears RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (pre_en[d]) mem[d][pre_a] <= pre_v[d];
      else if (ram_wr_en[d]) mem[d][ram_addr[d]] <= ram_wr_data[d];
      p1[d] <= ram_rd_en[d] ? mem[d][ram_addr[d]] : 8'($urandom);
      p2[d] <= p1[d];
    end
  end

  assign ram_rd_data[0] = p1[0];
  assign ram_rd_data[1] = p1[1];
  assign ram_rd_data[2] = p2[2];

  function automatic int cols_of(input int d);
    return (d == 1) ? 96 : 128;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int pix_addr(input int x, input int y);
    return (y / 8) * 128 + x;
  endfunction

  function automatic logic [7:0] pix_apply(input logic [7:0] b, input int y, input int op);
    logic [7:0] m;
    m = 8'(1 << (y % 8));
    case (op)
      0:       return b & ~m;
      1:       return b | m;
      2:       return b ^ m;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int d, input int a, input logic [7:0] v);
    pre_en[d] = 1'b1;
    pre_a     = 10'(a);
    pre_v[d]  = v;
    step();
    pre_en = '0;
    ref_mem[d][a] = v;
  endtask

  task automatic chk_reset(input int d);
    string t;
    t = $sformatf("reset d%0d", d);
    chk({t, " ready"}, req_ready[d], 1);
    chk({t, " rd_en"}, ram_rd_en[d], 0);
    chk({t, " wr_en"}, ram_wr_en[d], 0);
    chk({t, " done"}, done[d], 0);
    chk({t, " err"}, err[d], 0);
    chk({t, " busy"}, busy[d], 0);
    chk({t, " addr"}, ram_addr[d], 0);
    chk({t, " wr_data"}, ram_wr_data[d], 0);
    chk({t, " dirty"}, dirty[d], 0);
  endtask

  task automatic do_pixel(input int d, input int x, input int y, input int op,
                          input logic [7:0] exp_data, input logic [7:0] clr_w);
    string t;
    int a;
    t = $sformatf("pix d%0d x%0d y%0d op%0d", d, x, y, op);
    a = pix_addr(x, y);
    chk({t, " ready_before"}, req_ready[d], 1);
    req_valid[d] = 1'b1;
    xx[d] = 7'(x);
    yy[d] = 6'(y);
    op_in[d] = 2'(op);
    step();
    req_valid[d] = 1'b0;
    xx[d] = 7'($urandom);
    yy[d] = 6'($urandom);
    op_in[d] = 2'($urandom);
    chk({t, " rd_en"}, ram_rd_en[d], 1);
    chk({t, " rd_addr"}, ram_addr[d], 32'(a));
    chk({t, " ready_busy"}, req_ready[d], 0);
    chk({t, " busy"}, busy[d], 1);
    for (int k = 0; k < lat_of(d); k++) begin
      step();
      chk({t, " wait_strobes"}, {ram_rd_en[d], ram_wr_en[d], done[d]}, 0);
    end
    step();
    dirty_clr[d] = clr_w;
    chk({t, " wr_en"}, ram_wr_en[d], 1);
    chk({t, " done"}, {done[d], err[d]}, 2'b10);
    chk({t, " wr_data"}, ram_wr_data[d], exp_data);
    chk({t, " wr_addr"}, ram_addr[d], 32'(a));
    step();
    dirty_clr[d] = 8'h00;
    chk({t, " ready_after"}, req_ready[d], 1);
    chk({t, " idle_strobes"}, {busy[d], done[d], ram_wr_en[d]}, 0);
    ref_mem[d][a] = exp_data;
    dirty_exp[d] = (dirty_exp[d] & ~clr_w) | (DIRTY_EN ? 8'(1 << (y / 8)) : 8'h00);
    chk({t, " dirty"}, dirty[d], dirty_exp[d]);
    chk({t, " ram_byte"}, mem[d][a], exp_data);
  endtask

  task automatic do_err(input int d, input int x, input int y, input int op);
    string t;
    t = $sformatf("err d%0d x%0d", d, x);
    chk({t, " ready_before"}, req_ready[d], 1);
    req_valid[d] = 1'b1;
    xx[d] = 7'(x);
    yy[d] = 6'(y);
    op_in[d] = 2'(op);
    step();
    req_valid[d] = 1'b0;
    chk({t, " done_err"}, {done[d], err[d]}, 2'b11);
    chk({t, " no_strobes"}, {ram_rd_en[d], ram_wr_en[d]}, 0);
    chk({t, " ready_busy"}, {req_ready[d], busy[d]}, 2'b01);
    step();
    chk({t, " ready_after"}, {req_ready[d], busy[d]}, 2'b10);
    chk({t, " after_strobes"}, {done[d], err[d], ram_rd_en[d], ram_wr_en[d]}, 0);
  endtask

  task automatic pulse_clr(input int d, input logic [7:0] v);
    dirty_clr[d] = v;
    step();
    dirty_clr[d] = 8'h00;
    dirty_exp[d] = dirty_exp[d] & ~v;
    chk($sformatf("clr d%0d %02h", d, v), dirty[d], dirty_exp[d]);
  endtask

  typedef struct {
    int         d;
    int         x;
    int         y;
    int         op;
    logic [7:0] init;
    logic [7:0] exp;
    int         addr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 37, 29, 1, 8'h00, 8'h20, 'h1A5};
    vecs[1] = '{2, 127, 63, 1, 8'h01, 8'h81, 'h3FF};
    vecs[2] = '{0, 5, 12, 2, 8'h10, 8'h00, 'h085};
    vecs[3] = '{1, 95, 40, 0, 8'hFF, 8'hFE, 'h2DF};
    vecs[4] = '{0, 10, 7, 3, 8'h5A, 8'h5A, 'h00A};
    vecs[5] = '{2, 0, 56, 2, 8'h00, 8'h01, 'h380};

    rst_n  = 1'b0;
    pre_en = '0;
    pre_a  = '0;
    for (int d = 0; d < N; d++) begin
      req_valid[d] = 1'b0;
      xx[d] = '0;
      yy[d] = '0;
      op_in[d] = '0;
      dirty_clr[d] = '0;
      pre_v[d] = '0;
      dirty_exp[d] = '0;
    end
    repeat (3) step();
    for (int d = 0; d < N; d++) chk_reset(d);
    rst_n = 1'b1;
    step();

    for (int a = 0; a < 1024; a++) begin
      pre_a = 10'(a);
      for (int d = 0; d < N; d++) begin
        pre_v[d] = 8'($urandom);
        ref_mem[d][a] = pre_v[d];
      end
      pre_en = '1;
      step();
    end
    pre_en = '0;

    foreach (vecs[i]) begin
      preload(vecs[i].d, vecs[i].addr, vecs[i].init);
      do_pixel(vecs[i].d, vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].exp, 8'h00);
    end

    // Back-to-back with valid held: second request is taken on the first IDLE cycle.
    preload(0, 0, 8'hFF);
    req_valid[0] = 1'b1;
    xx[0] = 7'd0;
    yy[0] = 6'd0;
    op_in[0] = 2'd0;
    step();
    chk("b2b first rd", {ram_rd_en[0], ram_addr[0]}, {1'b1, 10'h000});
    yy[0] = 6'd7;
    op_in[0] = 2'd2;
    step();
    chk("b2b wait ready", req_ready[0], 0);
    step();
    chk("b2b first wr", {ram_wr_en[0], ram_wr_data[0], req_ready[0]}, {1'b1, 8'hFE, 1'b0});
    step();
    chk("b2b ready T+4", req_ready[0], 1);
    step();
    req_valid[0] = 1'b0;
    chk("b2b second rd", {ram_rd_en[0], ram_addr[0]}, {1'b1, 10'h000});
    step();
    step();
    chk("b2b second wr", {ram_wr_en[0], done[0], ram_wr_data[0]}, {2'b11, 8'h7E});
    step();
    chk("b2b ready after", req_ready[0], 1);
    ref_mem[0][0] = 8'h7E;
    dirty_exp[0] = dirty_exp[0] | (DIRTY_EN ? 8'h01 : 8'h00);
    chk("b2b dirty", dirty[0], dirty_exp[0]);
    chk("b2b ram", mem[0][0], 8'h7E);

    do_err(1, 100, 10, 1);
    do_err(1, 96, 63, 2);
    do_pixel(1, 95, 0, 1, pix_apply(ref_mem[1][pix_addr(95, 0)], 0, 1), 8'h00);

    pulse_clr(0, 8'hFF);
    do_pixel(0, 3, 20, 1, pix_apply(ref_mem[0][pix_addr(3, 20)], 20, 1), 8'h00);
    do_pixel(0, 4, 17, 1, pix_apply(ref_mem[0][pix_addr(4, 17)], 17, 1), 8'h04);
    chk("dirty set wins", dirty[0], DIRTY_EN ? 8'h04 : 8'h00);
    pulse_clr(0, 8'h04);
    chk("dirty lone clear", dirty[0], 8'h00);

    // Reset during WAIT must abort without touching the RAM byte.
    preload(0, 'h55, 8'h00);
    req_valid[0] = 1'b1;
    xx[0] = 7'd85;
    yy[0] = 6'd0;
    op_in[0] = 2'd1;
    step();
    req_valid[0] = 1'b0;
    chk("rst op rd", ram_rd_en[0], 1);
    step();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      chk_reset(d);
      dirty_exp[d] = 8'h00;
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rst no write", {ram_wr_en[0], done[0]}, 0);
    end
    chk("rst ram untouched", mem[0]['h55], 8'h00);
    do_pixel(0, 85, 0, 1, 8'h01, 8'h00);

    for (int i = 0; i < 60; i++) begin
      int d, x, y, op;
      logic [7:0] clr;
      d  = int'($urandom_range(0, N - 1));
      x  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
      y  = int'($urandom_range(0, 63));
      op = int'($urandom_range(0, 3));
      clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if (x >= cols_of(d)) do_err(d, x, y, op);
      else do_pixel(d, x, y, op, pix_apply(ref_mem[d][pix_addr(x, y)], y, op), clr);
    end

    for (int d = 0; d < N; d++) begin
      int bad;
      bad = 0;
      for (int a = 0; a < 1024; a++) if (mem[d][a] !== ref_mem[d][a]) bad++;
      chk($sformatf("ram sweep d%0d", d), 32'(bad), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
